pipeline_hazard_scoreboard: RTL and testbench



---
 rtl/cpu_pipe_pkg.sv | 36 +++
 rtl/hazard_lookup.sv | 45 ++++
 rtl/pipeline_hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared types and helpers for the pipelined CPU hazard/forwarding logic.
//   sb_entry_t  : one in-flight register write {valid, rd, ready}
//   SEL_REGFILE : forwarding select value meaning "use the register file"
//   STAGE_EX    : index of the first stage after ID
//   clamp_ready : maps a raw ready-stage request into 1..depth
// Entry fields are sized for the largest supported configuration
// (AW <= SB_AW_MAX, SW <= SB_SW_MAX). Narrower register numbers and ready
// fields are zero-extended into them.
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam int SB_AW_MAX   = 8;
  localparam int SB_SW_MAX   = 8;
  localparam int SEL_REGFILE = 0;
  localparam int STAGE_EX    = 1;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_MAX-1:0] rd;
    logic [SB_SW_MAX-1:0] ready;
  } sb_entry_t;

  // A result can never be available before EX, nor later than the last
  // tracked stage, so requests outside 1..depth are pulled to the nearest end.
  function automatic logic [SB_SW_MAX-1:0] clamp_ready(
    input logic [SB_SW_MAX-1:0] ready,
    input int                   depth
  );
    if (ready == '0) return SB_SW_MAX'(STAGE_EX);
    if (int'(ready) > depth) return SB_SW_MAX'(depth);
    return ready;
  endfunction

endpackage

// File: rtl/hazard_lookup.sv
// -----------------------------------------------------------------------------
// hazard_lookup
// Priority search of the scoreboard for one source operand.
//   entries   in  scoreboard, index k = stage k after ID (1 = EX)
//   src       in  source register number
//   used      in  operand is actually read
//   hit       out a valid in-flight write to src exists
//   stage     out youngest (lowest-index) matching stage
//   not_ready out the youngest match has not produced its result yet
// Register 0 never matches.
// -----------------------------------------------------------------------------
module hazard_lookup
  import cpu_pipe_pkg::*;
#(
  parameter int AW    = 5,
  parameter int SW    = 2,
  parameter int DEPTH = 3
) (
  input  sb_entry_t       entries [1:DEPTH],
  input  logic [AW-1:0]   src,
  input  logic            used,
  output logic            hit,
  output logic [SW-1:0]   stage,
  output logic            not_ready
);

  // NOTE: every output gets a default before the search so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    hit       = 1'b0;
    stage     = '0;
    not_ready = 1'b0;
    if (used && (src != '0)) begin
      // Scan oldest to youngest; the last match written is the youngest.
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries[k].valid && (entries[k].rd == SB_AW_MAX'(src))) begin
          hit       = 1'b1;
          stage     = SW'(k);
          not_ready = k < int'(entries[k].ready);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_scoreboard
// Hazard and forwarding unit beside the ID stage. Tracks in-flight register
// writes over DEPTH post-ID stages and the stage at which each result becomes
// valid, raises the ID stall and selects forwarded operand data.
//   clock, resetn          clock, asynchronous active-low reset
//   id_valid/flush         ID holds a real instruction / it is squashed
//   id_rs, id_rs_used      first source register and its use flag
//   id_rt, id_rt_used      second source register and its use flag
//   id_rd, id_wreg         destination register and write enable
//   id_ready               first stage (1..DEPTH) where the result is valid
//   reg_a, reg_b           register file reads for rs / rt
//   stage_data             stage k result at bits [k*DW-1:(k-1)*DW]
//   stall                  hold PC and IF/ID, bubble into EX
//   fwd_sel_a/b            0 = register file, k = stage k
//   fwd_data_a/b           forwarded operand values
//   stall_count            saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = 2,
  parameter int CNTW  = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic              id_rs_used,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_rt_used,
  input  logic [AW-1:0]     id_rd,
  input  logic              id_wreg,
  input  logic [SW-1:0]     id_ready,
  input  logic              flush,
  input  logic [DW-1:0]     reg_a,
  input  logic [DW-1:0]     reg_b,
  input  logic [DW*DEPTH-1:0] stage_data,
  output logic              stall,
  output logic [SW-1:0]     fwd_sel_a,
  output logic [DW-1:0]     fwd_data_a,
  output logic [SW-1:0]     fwd_sel_b,
  output logic [DW-1:0]     fwd_data_b,
  output logic [CNTW-1:0]   stall_count
);

  sb_entry_t       pipe [1:DEPTH];
  sb_entry_t       load_entry;
  logic            hit_a, hit_b, nr_a, nr_b;
  logic [SW-1:0]   stage_a, stage_b;

  hazard_lookup #(.AW(AW), .SW(SW), .DEPTH(DEPTH)) u_lookup_a (
    .entries   (pipe),
    .src       (id_rs),
    .used      (id_rs_used),
    .hit       (hit_a),
    .stage     (stage_a),
    .not_ready (nr_a)
  );

  hazard_lookup #(.AW(AW), .SW(SW), .DEPTH(DEPTH)) u_lookup_b (
    .entries   (pipe),
    .src       (id_rt),
    .used      (id_rt_used),
    .hit       (hit_b),
    .stage     (stage_b),
    .not_ready (nr_b)
  );

  // A squashed instruction can never hold the pipe.
  assign stall = id_valid && !flush && (nr_a || nr_b);

  // Only an instruction actually leaving ID enters EX; everything else is a
  // bubble. Writes to register 0 are dropped here so they never match.
  always_comb begin
    load_entry = '0;
    if (id_valid && !flush && !stall) begin
      load_entry.valid = id_wreg && (id_rd != '0);
      load_entry.rd    = SB_AW_MAX'(id_rd);
      load_entry.ready = clamp_ready(SB_SW_MAX'(id_ready), DEPTH);
    end
  end

  // NOTE: the whole shift register is reset, not just a pointer: the valid
  // bits must clear so instructions in flight at reset are forgotten.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= DEPTH; k++) pipe[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its
      // predecessor's old value, independent of statement order.
      pipe[1] <= load_entry;
      for (int k = 2; k <= DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNTW'(1);
    end
  end

  // Forwarding mux; while stalled it still shows the raw lookup result.
  always_comb begin
    fwd_sel_a  = hit_a ? stage_a : SW'(SEL_REGFILE);
    fwd_sel_b  = hit_b ? stage_b : SW'(SEL_REGFILE);
    fwd_data_a = reg_a;
    fwd_data_b = reg_b;
    for (int k = 1; k <= DEPTH; k++) begin
      if (hit_a && (stage_a == SW'(k))) fwd_data_a = stage_data[(k-1)*DW +: DW];
      if (hit_b && (stage_b == SW'(k))) fwd_data_b = stage_data[(k-1)*DW +: DW];
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_scoreboard
// Drives two scoreboards side by side from the same ID-stage inputs:
//   u_d3 : DEPTH=3, SW=2, 32-bit stall counter
//   u_d5 : DEPTH=5, SW=3, 3-bit stall counter (saturates at 7)
// The reference model keeps, per configuration, the history of what entered
// EX each cycle (newest first) and answers lookups from the hazard rules.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_scoreboard;

  logic         clock;
  logic         resetn;
  logic         id_valid, id_rs_used, id_rt_used, id_wreg, flush;
  logic [4:0]   id_rs, id_rt, id_rd;
  logic [2:0]   id_ready;
  logic [31:0]  reg_a, reg_b;
  logic [159:0] sd;

  logic         stall3, stall5;
  logic [1:0]   sel_a3, sel_b3;
  logic [2:0]   sel_a5, sel_b5;
  logic [31:0]  data_a3, data_b3, data_a5, data_b5;
  logic [31:0]  cnt3;
  logic [2:0]   cnt5;

  pipeline_hazard_scoreboard #(.DW(32), .AW(5), .DEPTH(3), .SW(2), .CNTW(32)) u_d3 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wreg(id_wreg), .id_ready(id_ready[1:0]), .flush(flush),
    .reg_a(reg_a), .reg_b(reg_b), .stage_data(sd[95:0]),
    .stall(stall3), .fwd_sel_a(sel_a3), .fwd_data_a(data_a3),
    .fwd_sel_b(sel_b3), .fwd_data_b(data_b3), .stall_count(cnt3)
  );

  pipeline_hazard_scoreboard #(.DW(32), .AW(5), .DEPTH(5), .SW(3), .CNTW(3)) u_d5 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_wreg(id_wreg), .id_ready(id_ready), .flush(flush),
    .reg_a(reg_a), .reg_b(reg_b), .stage_data(sd),
    .stall(stall5), .fwd_sel_a(sel_a5), .fwd_data_a(data_a5),
    .fwd_sel_b(sel_b5), .fwd_data_b(data_b5), .stall_count(cnt5)
  );

  // Outputs gathered per configuration (0 = DEPTH 3, 1 = DEPTH 5).
  logic        st_o  [2];
  logic [2:0]  sa_o  [2];
  logic [2:0]  sb_o  [2];
  logic [31:0] da_o  [2];
  logic [31:0] db_o  [2];
  logic [31:0] cnt_o [2];

  assign st_o[0]  = stall3;
  assign st_o[1]  = stall5;
  assign sa_o[0]  = {1'b0, sel_a3};
  assign sa_o[1]  = sel_a5;
  assign sb_o[0]  = {1'b0, sel_b3};
  assign sb_o[1]  = sel_b5;
  assign da_o[0]  = data_a3;
  assign da_o[1]  = data_a5;
  assign db_o[0]  = data_b3;
  assign db_o[1]  = data_b5;
  assign cnt_o[0] = cnt3;
  assign cnt_o[1] = {29'd0, cnt5};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int rd;
    int rdy;
  } rec_t;

  rec_t    hist3[$];
  rec_t    hist5[$];
  longint  m_cnt [2];
  bit      exp_st [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 3 : 5;
  endfunction

  function automatic longint cnt_max(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd7;
  endfunction

  // id_ready as seen by each configuration's narrower or wider port.
  function automatic int raw_ready(input int d);
    return (d == 0) ? int'(id_ready[1:0]) : int'(id_ready);
  endfunction

  function automatic int eff_ready(input int d, input int raw);
    if (raw == 0) return 1;
    if (raw > depth_of(d)) return depth_of(d);
    return raw;
  endfunction

  // Instruction that entered EX k-1 cycles ago is at stage k now.
  function automatic rec_t get_rec(input int d, input int k);
    rec_t r;
    r = '{v: 1'b0, rd: 0, rdy: 0};
    if (d == 0) begin
      if (k - 1 < hist3.size()) r = hist3[k-1];
    end else begin
      if (k - 1 < hist5.size()) r = hist5[k-1];
    end
    return r;
  endfunction

  task automatic lookup(input int d, input int src, input bit used,
                        output bit hit, output int k, output bit nr);
    rec_t r;
    hit = 1'b0;
    k   = 0;
    nr  = 1'b0;
    if (used && src != 0) begin
      for (int j = 1; j <= depth_of(d) && !hit; j++) begin
        r = get_rec(d, j);
        if (r.v && r.rd == src) begin
          hit = 1'b1;
          k   = j;
          nr  = j < eff_ready(d, r.rdy);
        end
      end
    end
  endtask

  function automatic logic [31:0] slice(input int k);
    return sd[(k-1)*32 +: 32];
  endfunction

  task automatic model_compare();
    bit ha, hb, nra, nrb;
    int ka, kb;
    for (int d = 0; d < 2; d++) begin
      lookup(d, int'(id_rs), id_rs_used, ha, ka, nra);
      lookup(d, int'(id_rt), id_rt_used, hb, kb, nrb);
      exp_st[d] = id_valid && !flush && (nra || nrb);
      check($sformatf("d%0d stall", depth_of(d)), st_o[d], exp_st[d]);
      if (!nra) begin
        check($sformatf("d%0d sel_a", depth_of(d)), sa_o[d], ha ? ka : 0);
        check($sformatf("d%0d data_a", depth_of(d)), da_o[d], ha ? slice(ka) : reg_a);
      end
      if (!nrb) begin
        check($sformatf("d%0d sel_b", depth_of(d)), sb_o[d], hb ? kb : 0);
        check($sformatf("d%0d data_b", depth_of(d)), db_o[d], hb ? slice(kb) : reg_b);
      end
    end
  endtask

  task automatic model_commit();
    rec_t r;
    for (int d = 0; d < 2; d++) begin
      r.v   = id_valid && !flush && !exp_st[d] && id_wreg && (id_rd != 5'd0);
      r.rd  = int'(id_rd);
      r.rdy = raw_ready(d);
      if (d == 0) begin
        hist3.push_front(r);
        if (hist3.size() > 3) void'(hist3.pop_back());
      end else begin
        hist5.push_front(r);
        if (hist5.size() > 5) void'(hist5.pop_back());
      end
      if (exp_st[d] && m_cnt[d] < cnt_max(d)) m_cnt[d]++;
    end
  endtask

  task automatic model_reset();
    hist3.delete();
    hist5.delete();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit w, input int rdy, input bit fl);
    id_valid   = v;
    id_rs      = 5'(rs);
    id_rs_used = rsu;
    id_rt      = 5'(rt);
    id_rt_used = rtu;
    id_rd      = 5'(rd);
    id_wreg    = w;
    id_ready   = 3'(rdy);
    flush      = fl;
    reg_a      = $urandom;
    reg_b      = $urandom;
    for (int k = 0; k < 5; k++) sd[k*32 +: 32] = $urandom;
    #1;
  endtask

  task automatic set_sd(input int k, input logic [31:0] val);
    sd[(k-1)*32 +: 32] = val;
    #1;
  endtask

  task automatic tick();
    model_compare();
    @(posedge clock);
    model_commit();
    #1;
    check("d3 stall_count", cnt_o[0], m_cnt[0]);
    check("d5 stall_count", cnt_o[1], m_cnt[1]);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    check("reset stall", stall3, 1'b0);
    check("reset sel_a", sel_a3, 2'd0);
    check("reset data_a", data_a3, reg_a);
    check("reset count", cnt3, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // ALU back-to-back: add r3 then a consumer of r3.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    tick();
    drive(1, 3, 1, 0, 0, 8, 1, 1, 0);
    set_sd(1, 32'h0000_0042);
    check("alu stall", stall3, 1'b0);
    check("alu sel_a", sel_a3, 2'd1);
    check("alu data_a", data_a3, 32'h0000_0042);
    tick();
    bubbles(5);

    // Load-use: lw r5 (ready 2) then a consumer of r5 on rt.
    drive(1, 0, 0, 0, 0, 5, 1, 2, 0);
    tick();
    drive(1, 0, 0, 5, 1, 10, 1, 1, 0);
    check("ldu stall d3", stall3, 1'b1);
    check("ldu stall d5", stall5, 1'b1);
    check("ldu count before", cnt3, 32'd0);
    tick();
    check("ldu count after", cnt3, 32'd1);
    drive(1, 0, 0, 5, 1, 10, 1, 1, 0);
    set_sd(2, 32'hDEAD_BEEF);
    check("ldu resume stall", stall3, 1'b0);
    check("ldu sel_b", sel_b3, 2'd2);
    check("ldu data_b", data_b3, 32'hDEAD_BEEF);
    tick();
    bubbles(5);

    // Youngest wins: r7 at stage 3 and at stage 1.
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    bubbles(1);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 1, 0);
    set_sd(1, 32'h0000_0022);
    set_sd(3, 32'h0000_0011);
    check("young sel_a", sel_a3, 2'd1);
    check("young data_a", data_a3, 32'h0000_0022);
    tick();
    bubbles(5);

    // Register 0 never matches.
    drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
    tick();
    drive(1, 0, 1, 0, 1, 12, 1, 1, 0);
    check("r0 stall", stall3, 1'b0);
    check("r0 sel_a", sel_a3, 2'd0);
    check("r0 data_a", data_a3, reg_a);
    tick();
    bubbles(5);

    // Flush: dependent op squashed, its r9 write must not appear.
    drive(1, 0, 0, 0, 0, 4, 1, 2, 0);
    tick();
    drive(1, 4, 1, 0, 0, 9, 1, 1, 1);
    check("flush stall", stall3, 1'b0);
    tick();
    drive(1, 9, 1, 4, 1, 0, 0, 1, 0);
    check("flush next stall", stall3, 1'b0);
    check("flush bubble sel_a", sel_a3, 2'd0);
    check("flush lw sel_b", sel_b3, 2'd2);
    tick();
    bubbles(5);

    // DEPTH 5, ready 4: three stall cycles then forward from stage 4.
    // Repeated so the 3-bit counter saturates.
    for (int rep = 0; rep < 3; rep++) begin
      drive(1, 0, 0, 0, 0, 6, 1, 4, 0);
      tick();
      for (int c = 0; c < 3; c++) begin
        drive(1, 6, 1, 0, 0, 11, 1, 1, 0);
        check("deep stall", stall5, 1'b1);
        tick();
      end
      drive(1, 6, 1, 0, 0, 11, 1, 1, 0);
      check("deep resume", stall5, 1'b0);
      check("deep sel_a", sel_a5, 3'd4);
      tick();
      bubbles(5);
    end
    check("deep count saturated", cnt5, 3'd7);

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 0, 0, 0, 5, 1, 3, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 1, 0);
    check("pre-reset stall", stall3, 1'b1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("areset stall d3", stall3, 1'b0);
    check("areset stall d5", stall5, 1'b0);
    check("areset count d3", cnt3, 32'd0);
    check("areset count d5", cnt5, 3'd0);
    check("areset sel_a", sel_a3, 2'd0);
    check("areset data_a", data_a3, reg_a);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    drive(1, 5, 1, 0, 0, 0, 0, 1, 0);
    check("post-reset sel_a", sel_a3, 2'd0);
    tick();

    // Randomized traffic over a small register window for frequent hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
